// File: rtl/pixel_packer_pkg.sv
// rtl/pixel_packer_pkg.sv - shared types, widths and nibble helpers for pixel_write_packer
package pixel_packer_pkg;

  localparam int NIBBLES_PER_WORD = 4;
  localparam int PIX_ADDR_W       = 18;
  localparam int FB_ADDR_W        = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  nib_en;
  } fb_word_t;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_HOLD  = 1'b1
  } acc_state_e;

  function automatic logic [15:0] set_nibble(input logic [15:0] word,
                                             input logic [1:0]  k,
                                             input logic [3:0]  val);
    logic [15:0] r;
    r = word;
    r[{k, 2'b00} +: 4] = val;
    return r;
  endfunction

  function automatic logic [3:0] nib_onehot(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; a write while full is taken only with a same-cycle read
import pixel_packer_pkg::*;

module sync_fifo #(
  parameter int WIDTH = $bits(fb_word_t),
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             wr_take;
  logic             rd_take;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_take = rd_en && !empty;
  assign wr_take = wr_en && (!full || rd_take);

  // Head is forced to zero when empty so the outputs read as zero after reset.
  assign rd_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_take) wptr_d = wptr_q + PTR_ONE;
    if (rd_take) rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_take) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pixel_write_packer.sv
// rtl/pixel_write_packer.sv - coalesces 4-bit pixel writes into masked 16-bit framebuffer words
// Optional PIXEL_PACKER_STATS_EN adds words_written / words_dropped saturating counters.
import pixel_packer_pkg::*;

module pixel_write_packer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_wr_en,
  input  logic [17:0] pix_wr_addr,
  input  logic [3:0]  pix_wr_data,
  input  logic        flush,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [15:0] fb_addr,
  output logic [15:0] fb_data,
  output logic [3:0]  fb_nib_en,
  output logic        overflow,
  output logic        idle
`ifdef PIXEL_PACKER_STATS_EN
  ,
  output logic [15:0] words_written,
  output logic [7:0]  words_dropped
`endif
);

  localparam logic [7:0] TMO_LAST = 8'(FLUSH_TIMEOUT - 1);

  acc_state_e  state_q, state_d;
  logic [15:0] acc_addr_q, acc_addr_d;
  logic [15:0] acc_data_q, acc_data_d;
  logic [3:0]  acc_mask_q, acc_mask_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        overflow_q, overflow_d;

  logic        push;
  fb_word_t    push_word;
  fb_word_t    head_word;
  logic        fifo_full, fifo_empty;
  logic        pop;
  logic        drop;

  logic [15:0] pix_word;
  logic [1:0]  pix_k;
  logic        same_word;
  logic        mask_full;
  logic [15:0] merged_data;
  logic [3:0]  merged_mask;
  logic [15:0] load_data;
  logic [3:0]  load_mask;

  assign pix_word    = pix_wr_addr[17:2];
  assign pix_k       = pix_wr_addr[1:0];
  assign same_word   = (acc_addr_q == pix_word);
  assign mask_full   = (acc_mask_q == 4'b1111);
  assign merged_data = set_nibble(acc_data_q, pix_k, pix_wr_data);
  assign merged_mask = acc_mask_q | nib_onehot(pix_k);
  assign load_data   = set_nibble(16'h0000, pix_k, pix_wr_data);
  assign load_mask   = nib_onehot(pix_k);

  always_comb begin
    state_d    = state_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    acc_mask_d = acc_mask_q;
    tmo_d      = tmo_q;
    push       = 1'b0;
    push_word  = '{addr: acc_addr_q, data: acc_data_q, nib_en: acc_mask_q};

    case (state_q)
      ACC_EMPTY: begin
        tmo_d = '0;
        if (pix_wr_en) begin
          acc_addr_d = pix_word;
          acc_data_d = load_data;
          acc_mask_d = load_mask;
          if (flush) begin
            // Nothing to merge with, so a flushed lone pixel leaves immediately.
            push       = 1'b1;
            push_word  = '{addr: pix_word, data: load_data, nib_en: load_mask};
            acc_mask_d = '0;
          end else begin
            state_d = ACC_HOLD;
          end
        end
      end

      ACC_HOLD: begin
        if (pix_wr_en) begin
          tmo_d = '0;
          if (same_word && flush) begin
            push       = 1'b1;
            push_word  = '{addr: acc_addr_q, data: merged_data, nib_en: merged_mask};
            acc_mask_d = '0;
            state_d    = ACC_EMPTY;
          end else if (same_word && !mask_full) begin
            acc_data_d = merged_data;
            acc_mask_d = merged_mask;
          end else begin
            // A full word is pushed even when the next pixel hits the same address.
            push       = 1'b1;
            acc_addr_d = pix_word;
            acc_data_d = load_data;
            acc_mask_d = load_mask;
          end
        end else if (flush || mask_full || (tmo_q == TMO_LAST)) begin
          push       = 1'b1;
          tmo_d      = '0;
          acc_mask_d = '0;
          state_d    = ACC_EMPTY;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      default: state_d = ACC_EMPTY;
    endcase
  end

  assign pop        = !fifo_empty && fb_ready;
  assign drop       = push && fifo_full && !pop;
  assign overflow_d = overflow_q || drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACC_EMPTY;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fb_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (fb_ready),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fb_valid  = !fifo_empty;
  assign fb_addr   = head_word.addr;
  assign fb_data   = head_word.data;
  assign fb_nib_en = head_word.nib_en;
  assign overflow  = overflow_q;
  assign idle      = (state_q == ACC_EMPTY) && fifo_empty && !flush;

`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0] words_written_q, words_written_d;
  logic [7:0]  words_dropped_q, words_dropped_d;

  always_comb begin
    words_written_d = words_written_q;
    words_dropped_d = words_dropped_q;
    if (pop && (words_written_q != 16'hFFFF)) words_written_d = words_written_q + 16'd1;
    if (drop && (words_dropped_q != 8'hFF))   words_dropped_d = words_dropped_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      words_written_q <= '0;
      words_dropped_q <= '0;
    end else begin
      words_written_q <= words_written_d;
      words_dropped_q <= words_dropped_d;
    end
  end

  assign words_written = words_written_q;
  assign words_dropped = words_dropped_q;
`endif

endmodule

// File: tb/tb_pixel_write_packer.sv
// tb/tb_pixel_write_packer.sv - scoreboard bench for pixel_write_packer (default 16-deep, timeout 8)
import pixel_packer_pkg::*;

module tb_pixel_write_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_wr_en;
  logic [17:0] pix_wr_addr;
  logic [3:0]  pix_wr_data;
  logic        flush;
  logic        fb_valid;
  logic        fb_ready;
  logic [15:0] fb_addr;
  logic [15:0] fb_data;
  logic [3:0]  fb_nib_en;
  logic        overflow;
  logic        idle;
`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0] words_written;
  logic [7:0]  words_dropped;
`endif

  pixel_write_packer dut (
    .clk         (clk),
    .reset       (reset),
    .pix_wr_en   (pix_wr_en),
    .pix_wr_addr (pix_wr_addr),
    .pix_wr_data (pix_wr_data),
    .flush       (flush),
    .fb_valid    (fb_valid),
    .fb_ready    (fb_ready),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_nib_en   (fb_nib_en),
    .overflow    (overflow),
    .idle        (idle)
`ifdef PIXEL_PACKER_STATS_EN
    ,
    .words_written (words_written),
    .words_dropped (words_dropped)
`endif
  );

  always #5 clk = ~clk;

  int       n_cmp  = 0;
  int       n_fail = 0;
  int       hs_cnt = 0;
  fb_word_t exp_q[$];
  logic     prev_stall = 1'b0;
  fb_word_t prev_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: a handshake is the upcoming edge where valid and ready are both high.
  always @(negedge clk) begin
    fb_word_t e;
    fb_word_t act;
    act = '{addr: fb_addr, data: fb_data, nib_en: fb_nib_en};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && fb_valid) chk("hold_stable", 64'(act), 64'(prev_word));
      if (fb_valid && fb_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(act), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("word", 64'(act), 64'(e));
        end
      end
      prev_stall = fb_valid && !fb_ready;
      prev_word  = act;
    end
  end

  task automatic drive(input logic en, input logic [17:0] a, input logic [3:0] d, input logic fl);
    pix_wr_en   = en;
    pix_wr_addr = a;
    pix_wr_data = d;
    flush       = fl;
    @(posedge clk);
    #1;
    pix_wr_en = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic expect_word(input logic [15:0] a, input logic [15:0] d, input logic [3:0] m);
    fb_word_t w;
    w = '{addr: a, data: d, nib_en: m};
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'h0);
    repeat (12) @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] seq_addr(input int base_word, input int i);
    logic [15:0] w;
    logic [1:0]  k;
    w = 16'(base_word + i);
    k = 2'(i % 4);
    return {w, k};
  endfunction

  function automatic logic [15:0] seq_data(input int i);
    logic [15:0] z;
    z = 16'h0000;
    return set_nibble(z, 2'(i % 4), 4'(i));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    pix_wr_en   = 1'b0;
    pix_wr_addr = '0;
    pix_wr_data = '0;
    flush       = 1'b0;
    fb_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(fb_valid), 64'h0);
    chk("rst_addr", 64'(fb_addr), 64'h0);
    chk("rst_data", 64'(fb_data), 64'h0);
    chk("rst_nib_en", 64'(fb_nib_en), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Four nibbles of one word; push forced one cycle after the mask completes.
    expect_word(16'h0004, 16'h4321, 4'b1111);
    drive(1'b1, 18'h00010, 4'h1, 1'b0);
    drive(1'b1, 18'h00011, 4'h2, 1'b0);
    drive(1'b1, 18'h00012, 4'h3, 1'b0);
    drive(1'b1, 18'h00013, 4'h4, 1'b0);
    chk("mask_push_early", 64'(fb_valid), 64'h0);
    @(posedge clk);
    #1;
    chk("mask_push_fire", 64'(fb_valid), 64'h1);
    wait_drain("drain_full_word");

    // Lone pixel leaves on the 8th idle cycle.
    expect_word(16'h0008, 16'h00A0, 4'b0010);
    drive(1'b1, 18'h00021, 4'hA, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk("tmo_early", 64'(fb_valid), 64'h0);
    @(posedge clk);
    #1;
    chk("tmo_fire", 64'(fb_valid), 64'h1);
    wait_drain("drain_timeout");
    chk("idle_after_drain", 64'(idle), 64'h1);

    // Repeated nibble: last write wins; flush gives valid the next cycle.
    expect_word(16'h0001, 16'h0070, 4'b0010);
    drive(1'b1, 18'h00005, 4'h3, 1'b0);
    drive(1'b1, 18'h00005, 4'h7, 1'b0);
    drive(1'b0, 18'h00000, 4'h0, 1'b1);
    chk("flush_latency", 64'(fb_valid), 64'h1);
    wait_drain("drain_last_wins");

    // Flush with a same-word pixel merges first.
    expect_word(16'h0010, 16'h0065, 4'b0011);
    drive(1'b1, 18'h00040, 4'h5, 1'b0);
    drive(1'b1, 18'h00041, 4'h6, 1'b1);
    wait_drain("drain_flush_same");

    // Flush with a different-word pixel pushes the old word, keeps the new one.
    expect_word(16'h0020, 16'h0001, 4'b0001);
    expect_word(16'h0021, 16'h0020, 4'b0010);
    drive(1'b1, 18'h00080, 4'h1, 1'b0);
    drive(1'b1, 18'h00085, 4'h2, 1'b1);
    wait_drain("drain_flush_diff");

    // Overflow: 16 words retained, the flushed 17th is dropped.
    fb_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expect_word(16'(16'h0040 + i), seq_data(i), 4'b0001 << (i % 4));
      drive(1'b1, seq_addr(16'h0040, i), 4'(i), 1'b0);
    end
    chk("ovf_before", 64'(overflow), 64'h0);
    drive(1'b0, 18'h00000, 4'h0, 1'b1);
    chk("ovf_set", 64'(overflow), 64'h1);
    fb_ready = 1'b1;
    wait_drain("drain_overflow");
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // Reset mid-burst discards queued words and the accumulator.
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, seq_addr(16'h0300, i), 4'(i), 1'b0);
    chk("rst_mid_pre_valid", 64'(fb_valid), 64'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("rst_mid_valid", 64'(fb_valid), 64'h0);
    chk("rst_mid_idle", 64'(idle), 64'h1);
    chk("rst_mid_overflow", 64'(overflow), 64'h0);
    reset    = 1'b0;
    fb_ready = 1'b1;
    hs_cnt   = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_mid_silence", 64'(hs_cnt), 64'h0);

    // Full FIFO with a push and a pop on the same edge: nothing is lost.
    fb_ready = 1'b0;
    for (int i = 0; i < 18; i++) expect_word(16'(16'h0080 + i), seq_data(i), 4'b0001 << (i % 4));
    for (int i = 0; i < 17; i++) drive(1'b1, seq_addr(16'h0080, i), 4'(i), 1'b0);
    fb_ready = 1'b1;
    drive(1'b1, seq_addr(16'h0080, 17), 4'(17), 1'b0);
    chk("full_pushpop_ovf", 64'(overflow), 64'h0);
    wait_drain("drain_full_pushpop");
    chk("full_pushpop_ovf_end", 64'(overflow), 64'h0);
    chk("final_idle", 64'(idle), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_packer.md
Name: pixel_write_packer

Overview:
- Sits directly downstream of the vector engine's pixel address generator.
- Consumes 4-bit pixel writes (18-bit pixel address) and coalesces writes to the same 16-bit framebuffer word into one masked word write.
- Buffers packed words in a small FIFO and presents them to the framebuffer SRAM arbiter over a valid/ready handshake.
- Gives the drawing pipeline, which has no backpressure, elastic decoupling from SRAM arbitration stalls.

Parameters:
- FIFO_DEPTH, 16, packed-word FIFO entries; power of two, 4 to 64.
- FLUSH_TIMEOUT, 8, idle cycles before a partially filled accumulator is pushed; range 1 to 255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_wr_en  in  1  pixel write strobe, one pixel per cycle
- pix_wr_addr  in  18  linear pixel address
- pix_wr_data  in  4  palette index for the pixel
- flush  in  1  single-cycle pulse; push the accumulator now (driven from the engine's done rising edge)
- fb_valid  out  1  packed word available
- fb_ready  in  1  arbiter accepts the word
- fb_addr  out  16  word address = pix_wr_addr[17:2]
- fb_data  out  16  four nibbles; nibble k at bits [4k+3:4k]
- fb_nib_en  out  4  nibble write enables
- overflow  out  1  sticky; a packed word was dropped
- idle  out  1  accumulator empty, FIFO empty, no flush pending

Behaviour:
- Reset values: fb_valid=0, fb_addr=0, fb_data=0, fb_nib_en=0, overflow=0, idle=1. Accumulator and FIFO are emptied and the timeout counter is cleared.
- Reset mid-operation discards all buffered pixels with no output.
- Nibble index: k = pix_wr_addr[1:0]. Word address: pix_wr_addr[17:2].
- Accumulator FSM, state ACC_EMPTY:
  - pix_wr_en loads addr, writes nibble k, sets mask = one-hot(k), and moves to ACC_HOLD.
- Accumulator FSM, state ACC_HOLD:
  - Same word address: merge; nibble k is overwritten and mask |= one-hot(k). A repeated nibble means last write wins.
  - Different word address: push the accumulator to the FIFO and load the new pixel in the same cycle. State stays ACC_HOLD.
  - flush with no pixel: push and go to ACC_EMPTY.
  - flush together with a pixel to a different word: push the old word, load the new pixel, stay ACC_HOLD. The new pixel is pushed by the next flush or timeout.
  - flush together with a pixel to the same word: merge first, then push the merged word, go to ACC_EMPTY.
  - Timeout counter increments each cycle without pix_wr_en and is cleared by pix_wr_en. Reaching FLUSH_TIMEOUT pushes the accumulator and goes to ACC_EMPTY.
  - A push is also forced when mask becomes 4'b1111, one cycle after the completing write.
- FIFO (show-ahead):
  - fb_valid = not empty. fb_addr, fb_data and fb_nib_en reflect the head entry.
  - Pop on fb_valid & fb_ready. Outputs must hold stable while fb_valid & !fb_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Push while full with no pop: the word is dropped and overflow is set and held until reset.
- Latency: a word pushed at clock edge N gives fb_valid=1 in the cycle after edge N, when the FIFO was empty.
- Throughput: one pixel per cycle in, one word per cycle out.

Optional Feature:
- Macro PIXEL_PACKER_STATS_EN.
- When defined: adds outputs words_written (16-bit, counts fb handshakes) and words_dropped (8-bit). Both saturate and reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package pixel_packer_pkg holds:
  - typedef fb_word_t as a packed struct {addr[15:0], data[15:0], nib_en[3:0]}.
  - NIBBLES_PER_WORD=4, PIX_ADDR_W=18, FB_ADDR_W=16.
- Sub-module sync_fifo, parameterised on width and depth. It stores fb_word_t, is show-ahead, and outputs full/empty.

Test Plan:
- Writes to addr 0x00010..0x00013, data 1,2,3,4 -> one word: fb_addr=0x0004, fb_data=0x4321, fb_nib_en=4'b1111.
- Write addr 0x00021 data 0xA, then idle 8 cycles -> push on timeout: fb_addr=0x0008, fb_data=0x00A0, fb_nib_en=4'b0010.
- Write addr 0x00005 data 3, then 0x00005 data 7, then flush -> single word: fb_data=0x0070, fb_nib_en=4'b0010.
- fb_ready=0 while 17 pixels go to distinct words, FIFO_DEPTH=16, then flush -> 16 words retained; the 17th word's push (at flush) is dropped; overflow=1; release fb_ready -> 16 words drain in order.
- With the FIFO full and fb_ready=1, a new push in the same cycle as a pop -> no drop, overflow stays 0.
- Assert reset mid-burst with 5 words queued -> fb_valid=0 and idle=1 the next cycle; nothing is emitted afterwards.
